// File: rtl/iter_shifter_if.sv
// Request/response bundle between the execute stage and iter_shifter.
// Handshake: the shifter accepts start only when busy=0 (IDLE or DONE); done is a one-cycle result-valid pulse.
interface iter_shifter_if #(
    parameter int WIDTH = 32
) ();
    localparam int SHW = $clog2(WIDTH);

    logic             start;
    logic [1:0]       op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;

    modport master (
        output start, op, shamt, din,
        input  busy, done, dout
    );

    modport slave (
        input  start, op, shamt, din,
        output busy, done, dout
    );
endinterface

// File: rtl/iter_shifter.sv
// Multi-cycle SLL/SRL/SRA shifter moving at most STEP bits per clock.
// Optional rotate-right on op=11 is enabled by defining SHIFT_ROTATE_EN.
module iter_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic           clk,
    input  logic           rst,
    iter_shifter_if.slave  bus,
    output logic [1:0]     o_dbg_state
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_dout;
    logic [1:0]       r_op;
    logic [SHW-1:0]   r_rem;
    logic             r_sign;

    logic             w_accept;
    logic [SHW-1:0]   w_k;
    logic [WIDTH-1:0] w_fill_mask;
    logic [WIDTH-1:0] w_shifted;

`ifdef SHIFT_ROTATE_EN
    logic [SHW-1:0]   w_rot_amt;
    // k is always >= 1 while shifting, so WIDTH-k fits in SHW bits
    assign w_rot_amt = SHW'(WIDTH - int'(w_k));
`endif

    assign w_accept    = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start;
    assign w_fill_mask = ~({WIDTH{1'b1}} >> w_k);

    always_comb begin
        w_k = r_rem;
        if (int'(r_rem) > STEP) begin
            w_k = SHW'(STEP);
        end
    end

    always_comb begin
        w_shifted = r_work << w_k;
        case (r_op)
            2'b01:   w_shifted = r_work >> w_k;
            2'b10:   w_shifted = (r_work >> w_k) | (w_fill_mask & {WIDTH{r_sign}});
`ifdef SHIFT_ROTATE_EN
            2'b11:   w_shifted = (r_work >> w_k) | (r_work << w_rot_amt);
`else
            2'b11:   w_shifted = r_work << w_k;
`endif
            default: w_shifted = r_work << w_k;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_next_state = (bus.shamt == '0) ? S_DONE : S_SHIFT;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (r_rem == w_k) begin
                    w_next_state = S_DONE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_dout  <= '0;
            r_op    <= '0;
            r_rem   <= '0;
            r_sign  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_work <= bus.din;
                r_op   <= bus.op;
                r_rem  <= bus.shamt;
                r_sign <= bus.din[WIDTH-1];
                if (bus.shamt == '0) begin
                    r_dout <= bus.din;
                end
            end else if (r_state == S_SHIFT) begin
                r_work <= w_shifted;
                r_rem  <= r_rem - w_k;
                // result is published only on the final step, never mid-shift
                if (r_rem == w_k) begin
                    r_dout <= w_shifted;
                end
            end
        end
    end

    assign bus.busy    = (r_state == S_SHIFT);
    assign bus.done    = (r_state == S_DONE);
    assign bus.dout    = r_dout;
    assign o_dbg_state = r_state;
endmodule
